// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg
//   Shared definitions for the write-back stage: bus widths, the layout of
//   the MEM->WB result bus, the byte-enable codes used for load alignment,
//   and small extension helpers shared by the load aligner.
//   No ports (package).
package wb_stage_pkg;

  localparam int IN_BUS_WD = 111;
  localparam int BY_BUS_WD = 38;

  // Byte-enable codes carried with a load; anything not listed is a word.
  typedef enum logic [3:0] {
    BEN_B0   = 4'b0001,
    BEN_B1   = 4'b0010,
    BEN_B2   = 4'b0100,
    BEN_B3   = 4'b1000,
    BEN_HLO  = 4'b0011,
    BEN_HHI  = 4'b1100,
    BEN_WORD = 4'b1111
  } ben_e;

  // Field order matches the MEM stage packing, MSB first.
  typedef struct packed {
    logic [2:0]  valid_stage;
    logic        rf_w_en;
    logic        sel_wd;
    logic        sext;
    logic [3:0]  b_en;
    logic [31:0] ram_rdata;
    logic [4:0]  waddr;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } mem_to_wb_t;

  // Extend a byte to 32 bits, signed or unsigned.
  function automatic logic [31:0] ext_byte(input logic [7:0] val, input logic sext);
    return {{24{sext & val[7]}}, val};
  endfunction

  // Extend a halfword to 32 bits, signed or unsigned.
  function automatic logic [31:0] ext_half(input logic [15:0] val, input logic sext);
    return {{16{sext & val[15]}}, val};
  endfunction

endpackage

// File: rtl/wb_stage_load_align.sv
// load_align
//   Purely combinational load-data aligner. Picks the byte, halfword or
//   word addressed by the byte enables out of the raw RAM read data and
//   sign- or zero-extends it to 32 bits. Also used by the bypass unit to
//   forward MEM-stage loads, so it carries no state.
// Ports
//   ram_rdata    in  32  raw word read from data RAM
//   b_en         in  4   byte-enable code of the load
//   sext         in  1   1 = sign-extend byte/half, 0 = zero-extend
//   aligned_load out 32  aligned and extended load value
module load_align
  import wb_stage_pkg::*;
(
  input  logic [31:0] ram_rdata,
  input  logic [3:0]  b_en,
  input  logic        sext,
  output logic [31:0] aligned_load
);

  // Unknown byte-enable codes fall back to the full word so that a
  // malformed code never produces a partially zero result.
  always_comb begin
    aligned_load = ram_rdata;
    case (b_en)
      BEN_B0:  aligned_load = ext_byte(ram_rdata[7:0],   sext);
      BEN_B1:  aligned_load = ext_byte(ram_rdata[15:8],  sext);
      BEN_B2:  aligned_load = ext_byte(ram_rdata[23:16], sext);
      BEN_B3:  aligned_load = ext_byte(ram_rdata[31:24], sext);
      BEN_HLO: aligned_load = ext_half(ram_rdata[15:0],  sext);
      BEN_HHI: aligned_load = ext_half(ram_rdata[31:16], sext);
      default: aligned_load = ram_rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// wb_stage
//   Final pipeline stage (pipeline sink). Latches the MEM-stage result bus,
//   aligns load data, selects the write-back value and drives the register
//   file write port, the bypass bus and the debug trace.
// Ports
//   clk               in  1          clock, all state on posedge
//   reset             in  1          asynchronous reset, active low
//   MEM_to_WB_valid   in  1          upstream holds a valid instruction
//   WB_allow_in       out 1          stage can accept this cycle
//   MEM_to_WB_bus     in  IN_BUS_WD  packed mem_to_wb_t result bus
//   rf_we             out 1          register-file write enable
//   rf_waddr          out 5          register-file write address
//   rf_wdata          out 32         register-file write data
//   WB_to_BY_bus      out BY_BUS_WD  {by_valid, rf_waddr, rf_wdata}
//   debug_wb_pc       out 32         PC of the retiring instruction
//   debug_wb_rf_we    out 4          replicated rf_we
//   debug_wb_rf_wnum  out 5          register written
//   debug_wb_rf_wdata out 32         data written
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 MEM_to_WB_valid,
  output logic                 WB_allow_in,
  input  logic [IN_BUS_WD-1:0] MEM_to_WB_bus,
  output logic                 rf_we,
  output logic [4:0]           rf_waddr,
  output logic [31:0]          rf_wdata,
  output logic [BY_BUS_WD-1:0] WB_to_BY_bus,
  output logic [31:0]          debug_wb_pc,
  output logic [3:0]           debug_wb_rf_we,
  output logic [4:0]           debug_wb_rf_wnum,
  output logic [31:0]          debug_wb_rf_wdata
);

  // Write-back never stalls, so the stage always accepts.
  localparam logic WB_READY_GO = 1'b1;

  logic        wb_valid;
  mem_to_wb_t  wb_reg;
  logic [31:0] aligned_load;
  logic        wr_ok;
  logic        by_valid;
  logic [1:0]  unused_bits;

  assign WB_allow_in = ~wb_valid | WB_READY_GO;

  // Stage register. The payload only updates on a real handoff, so a
  // bubble leaves stale data behind but clears the valid bit, which gates
  // every enable downstream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_valid <= 1'b0;
      wb_reg   <= '0;
    end else if (WB_allow_in) begin
      wb_valid <= MEM_to_WB_valid;
      if (MEM_to_WB_valid) begin
        wb_reg <= mem_to_wb_t'(MEM_to_WB_bus);
      end
    end
  end

  load_align u_load_align (
    .ram_rdata    (wb_reg.ram_rdata),
    .b_en         (wb_reg.b_en),
    .sext         (wb_reg.sext),
    .aligned_load (aligned_load)
  );

  // r0 is hardwired to zero, so writes to it are dropped here rather than
  // in the register file; that also keeps them off the bypass bus.
  assign wr_ok    = wb_valid & wb_reg.rf_w_en & (wb_reg.waddr != 5'd0);
  assign by_valid = wr_ok & wb_reg.valid_stage[2];

  assign rf_we    = wr_ok;
  assign rf_waddr = wb_reg.waddr;
  assign rf_wdata = wb_reg.sel_wd ? aligned_load : wb_reg.alu_result;

  assign WB_to_BY_bus = {by_valid, rf_waddr, rf_wdata};

  assign debug_wb_pc       = wb_reg.pc;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

  // Lower stage-tracking bits are meaningful only to earlier stages.
  assign unused_bits = wb_reg.valid_stage[1:0];

endmodule
